// File: rtl/sprite_compositor.sv
// Two-stage priority compositor for N sprite layers. Layer 0 is the player and has the highest priority.
// It also tracks player/other-layer overlap per frame, latches the layer-enable mask once per frame, and counts frames.
module sprite_compositor #(
  parameter int                 N_LAYERS = 4,
  parameter int                 COLOR_W  = 8,
  parameter int                 COORD_W  = 32,
  parameter int                 H_ACTIVE = 640,
  parameter int                 V_ACTIVE = 480,
  parameter logic [COLOR_W-1:0] BG_COLOR = COLOR_W'('hFF),
  parameter int                 FRAME_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         pix_ce,
  input  logic [COORD_W-1:0]           x,
  input  logic [COORD_W-1:0]           y,
  input  logic [N_LAYERS-1:0]          layer_hit,
  input  logic [N_LAYERS*COLOR_W-1:0]  layer_color,
  input  logic [N_LAYERS-1:0]          layer_en,
  output logic [COLOR_W-1:0]           color_out,
  output logic                         active_out,
  output logic                         frame_start,
  output logic [FRAME_W-1:0]           frame_cnt,
  output logic                         collision,
  output logic                         collision_irq
);

  // Stage A registers
  logic [N_LAYERS-1:0]         hit_a;
  logic [N_LAYERS*COLOR_W-1:0] col_a;
  logic                        act_a;
  logic                        sof_a;

  logic [N_LAYERS-1:0]         en_q;
  logic                        acc;
  // Clear until the first (0,0) after reset, so that frame reports collision=0.
  logic                        seen_sof;

  logic [N_LAYERS-1:0]         eff;
  logic [COLOR_W-1:0]          pick;
  logic                        ovl;

  logic                        in_sof;
  logic                        in_act;

  assign in_sof = (x == '0) && (y == '0);
  assign in_act = (x < COORD_W'(H_ACTIVE)) && (y < COORD_W'(V_ACTIVE));
  assign eff    = hit_a & en_q;

  // Scan from the lowest priority upward so that the lowest set index wins.
  always_comb begin
    pick = BG_COLOR;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (eff[i]) pick = col_a[i*COLOR_W +: COLOR_W];
    end
  end

  generate
    if (N_LAYERS > 1) begin : g_ovl
      assign ovl = act_a && eff[0] && (|eff[N_LAYERS-1:1]);
    end else begin : g_no_ovl
      assign ovl = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_a         <= '0;
      col_a         <= '0;
      act_a         <= 1'b0;
      sof_a         <= 1'b0;
      en_q          <= '1;
      acc           <= 1'b0;
      seen_sof      <= 1'b0;
      color_out     <= '0;
      active_out    <= 1'b0;
      frame_start   <= 1'b0;
      frame_cnt     <= '0;
      collision     <= 1'b0;
      collision_irq <= 1'b0;
    end else begin
      frame_start   <= 1'b0;
      collision_irq <= 1'b0;
      if (pix_ce) begin
        hit_a <= layer_hit;
        col_a <= layer_color;
        act_a <= in_act;
        sof_a <= in_sof;
        if (in_sof) en_q <= layer_en;

        color_out  <= act_a ? pick : '0;
        active_out <= act_a;

        if (sof_a) begin
          collision     <= seen_sof & acc;
          collision_irq <= seen_sof & acc;
          frame_cnt     <= frame_cnt + FRAME_W'(1);
          frame_start   <= 1'b1;
          seen_sof      <= 1'b1;
          // The (0,0) pixel opens the new frame, so its own overlap starts the new accumulation.
          acc           <= ovl;
        end else if (ovl) begin
          acc <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Bench for sprite_compositor. It runs a table of directed pixels, hand sequences for the frame-level corner cases,
// and random pixels. All of them are checked against a per-pixel history model.
module tb_sprite_compositor;

  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic [31:0] x = '0;
  logic [31:0] y = '0;
  logic [3:0]  layer_hit = '0;
  logic [31:0] layer_color = '0;
  logic [3:0]  layer_en = 4'hF;
  logic [7:0]  color_out;
  logic        active_out;
  logic        frame_start;
  logic [FW-1:0] frame_cnt;
  logic        collision;
  logic        collision_irq;

  int total = 0;
  int bad = 0;

  sprite_compositor #(.FRAME_W(FW)) dut (
    .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce), .x(x), .y(y),
    .layer_hit(layer_hit), .layer_color(layer_color), .layer_en(layer_en),
    .color_out(color_out), .active_out(active_out), .frame_start(frame_start),
    .frame_cnt(frame_cnt), .collision(collision), .collision_irq(collision_irq)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  // model: one record per strobed pixel since the last reset
  typedef struct {
    logic       sof;
    logic       act;
    logic       ovl;
    logic [7:0] col;
  } pix_t;

  pix_t       hist[$];
  logic [3:0] cur_mask = 4'hF;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic model_push(input logic [31:0] px, input logic [31:0] py, input logic [3:0] hit,
                            input logic [31:0] cols, input logic [3:0] en);
    pix_t p;
    logic [3:0] eff;
    logic [7:0] c;
    p.sof = (px == 0) && (py == 0);
    if (p.sof) cur_mask = en;
    eff = hit & cur_mask;
    p.act = (px < 640) && (py < 480);
    c = 8'hFF;
    for (int i = 3; i >= 0; i--) if (eff[i]) c = cols[i*8 +: 8];
    p.col = p.act ? c : 8'h00;
    p.ovl = p.act && eff[0] && (eff[3:1] != 0);
    hist.push_back(p);
  endtask

  // Outputs describe the pixel strobed two strobes back. Collision covers the frame before the last (0,0).
  task automatic check_model(input bit after_strobe);
    int q = hist.size() - 2;
    int cnt = 0;
    int j = -1;
    int i = -1;
    logic [7:0] ec = 8'h00;
    logic ea = 1'b0;
    logic efs = 1'b0;
    logic ecol = 1'b0;
    if (q >= 0) begin
      ec = hist[q].col;
      ea = hist[q].act;
      efs = hist[q].sof;
    end
    for (int m = 0; m <= q; m++) begin
      if (hist[m].sof) begin
        cnt++;
        i = j;
        j = m;
      end
    end
    if (i >= 0) for (int m = i; m < j; m++) if (hist[m].ovl) ecol = 1'b1;
    if (!after_strobe) efs = 1'b0;
    check("m_color", 32'(color_out), 32'(ec));
    check("m_active", 32'(active_out), 32'(ea));
    check("m_frame_start", 32'(frame_start), 32'(efs));
    check("m_frame_cnt", 32'(frame_cnt), 32'(cnt % 16));
    check("m_collision", 32'(collision), 32'(ecol));
    check("m_irq", 32'(collision_irq), 32'(efs & ecol));
  endtask

  // driver
  task automatic strobe(input logic [31:0] px, input logic [31:0] py, input logic [3:0] hit,
                        input logic [31:0] cols, input logic [3:0] en);
    @(negedge clk);
    x = px; y = py; layer_hit = hit; layer_color = cols; layer_en = en;
    pix_ce = 1'b1;
    model_push(px, py, hit, cols, en);
    @(posedge clk);
    #1 check_model(1'b1);
    @(negedge clk);
    pix_ce = 1'b0;
    @(posedge clk);
    #1 check_model(1'b0);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      pix_ce = 1'b0;
      x = 0; y = 0; layer_hit = 4'hF; layer_en = 4'h0;
    end
    @(posedge clk);
    #1 check_model(1'b0);
  endtask

  task automatic neutral(input logic [31:0] cols);
    strobe(700, 700, 4'h0, cols, 4'hF);
  endtask

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  hit;
    logic [3:0]  en;
    logic [7:0]  exp_col;
    logic        exp_act;
  } vec_t;

  localparam logic [31:0] TCOLS = {8'h33, 8'hAA, 8'h25, 8'h11};

  initial begin
    vec_t tbl[12];
    logic [31:0] rc;
    int pick;

    tbl[0]  = '{5,   5,   4'b0000, 4'hF,    8'hFF, 1'b1};
    tbl[1]  = '{0,   0,   4'b0000, 4'hF,    8'hFF, 1'b1};
    tbl[2]  = '{5,   5,   4'b0110, 4'hF,    8'h25, 1'b1};
    tbl[3]  = '{639, 10,  4'b0000, 4'hF,    8'hFF, 1'b1};
    tbl[4]  = '{640, 10,  4'b1111, 4'hF,    8'h00, 1'b0};
    tbl[5]  = '{5,   480, 4'b1111, 4'hF,    8'h00, 1'b0};
    tbl[6]  = '{639, 479, 4'b1000, 4'hF,    8'h33, 1'b1};
    tbl[7]  = '{5,   5,   4'b0110, 4'b1101, 8'h25, 1'b1};
    tbl[8]  = '{0,   0,   4'b0110, 4'b1101, 8'hAA, 1'b1};
    tbl[9]  = '{5,   5,   4'b0110, 4'b1101, 8'hAA, 1'b1};
    tbl[10] = '{1,   1,   4'b0001, 4'b1101, 8'h11, 1'b1};
    tbl[11] = '{2,   1,   4'b1111, 4'b1101, 8'h11, 1'b1};

    // reset with pix_ce toggling
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      pix_ce = ~pix_ce;
      x = 0; y = 0; layer_hit = 4'hF;
    end
    #1 check_model(1'b1);
    @(negedge clk);
    pix_ce = 1'b0;
    rst_n = 1'b1;

    // directed table
    for (int t = 0; t < 12; t++) begin
      strobe(tbl[t].x, tbl[t].y, tbl[t].hit, TCOLS, tbl[t].en);
      strobe(700, 700, 4'h0, TCOLS, tbl[t].en);
      check($sformatf("tbl%0d_color", t), 32'(color_out), 32'(tbl[t].exp_col));
      check($sformatf("tbl%0d_active", t), 32'(active_out), 32'(tbl[t].exp_act));
    end

    // collision in frame k, then a clean frame k+1
    strobe(0, 0, 4'h0, TCOLS, 4'hF);
    strobe(3, 3, 4'b0011, TCOLS, 4'hF);
    strobe(0, 0, 4'h0, TCOLS, 4'hF);
    @(negedge clk);
    x = 700; y = 700; layer_hit = 4'h0; pix_ce = 1'b1;
    model_push(700, 700, 4'h0, TCOLS, 4'hF);
    @(posedge clk);
    #1 check("coll_k1", 32'(collision), 32'd1);
    check("irq_k1", 32'(collision_irq), 32'd1);
    @(negedge clk);
    pix_ce = 1'b0;
    @(posedge clk);
    #1 check("irq_k1_single", 32'(collision_irq), 32'd0);
    check("coll_k1_hold", 32'(collision), 32'd1);
    strobe(0, 0, 4'h0, TCOLS, 4'hF);
    neutral(TCOLS);
    check("coll_k2", 32'(collision), 32'd0);

    // pix_ce gap mid-line
    strobe(7, 7, 4'b0110, TCOLS, 4'hF);
    strobe(8, 7, 4'b0011, TCOLS, 4'hF);
    idle(3);
    check("gap_color", 32'(color_out), 32'h25);

    // frame counter wrap
    for (int k = 0; k < 17; k++) strobe(0, 0, 4'h0, TCOLS, 4'hF);
    neutral(TCOLS);

    // randomized pixels
    for (int k = 0; k < 400; k++) begin
      logic [31:0] rx, ry;
      pick = $urandom_range(0, 9);
      case (pick)
        0: begin rx = 0; ry = 0; end
        1: begin rx = 639; ry = $urandom_range(0, 479); end
        2: begin rx = 640; ry = $urandom_range(0, 479); end
        3: begin rx = $urandom_range(0, 639); ry = 479; end
        4: begin rx = $urandom_range(0, 639); ry = 480; end
        5: begin rx = 32'hFFFF_FFFF; ry = 2; end
        default: begin rx = $urandom_range(0, 700); ry = $urandom_range(0, 500); end
      endcase
      rc = $urandom;
      strobe(rx, ry, 4'($urandom_range(0, 15)), rc, 4'($urandom_range(0, 15)));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end

    // async reset mid-frame with acc set
    strobe(0, 0, 4'h0, TCOLS, 4'hF);
    strobe(3, 3, 4'b0011, TCOLS, 4'hF);
    neutral(TCOLS);
    check("pre_rst_color", 32'(color_out), 32'h11);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("arst_color", 32'(color_out), 32'd0);
    check("arst_cnt", 32'(frame_cnt), 32'd0);
    check("arst_active", 32'(active_out), 32'd0);
    hist.delete();
    cur_mask = 4'hF;
    @(negedge clk);
    rst_n = 1'b1;
    strobe(3, 3, 4'b0011, TCOLS, 4'hF);
    strobe(0, 0, 4'h0, TCOLS, 4'hF);
    neutral(TCOLS);
    check("rst_first_coll", 32'(collision), 32'd0);
    check("rst_first_cnt", 32'(frame_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
